// File: rtl/signed_bcd_digitizer.sv
// Sequential double-dabble converter: 16-bit two's-complement product to sign
// flag plus five BCD digits, one shift per clock, with a start/busy/done handshake.
module signed_bcd_digitizer #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             done,
  output logic             neg,
  output logic [3:0]       D0,
  output logic [3:0]       D1,
  output logic [3:0]       D2,
  output logic [3:0]       D3,
  output logic [3:0]       D4
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [WIDTH-1:0] mag;
  logic [CNT_W-1:0] count;
  logic             sign;

  // Add-3 correction is applied per nibble, so a carry can never spill into
  // the next digit.
  // NOTE: adj gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: every register here, working state included, is cleared by the
  // asynchronous reset so an aborted conversion leaves nothing behind; all
  // sequential updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      D0      <= 4'd0;
      D1      <= 4'd0;
      D2      <= 4'd0;
      D3      <= 4'd0;
      D4      <= 4'd0;
      scratch <= '0;
      mag     <= '0;
      count   <= '0;
      sign    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // 16'h8000 negates to itself, which reads as 32768 unsigned.
            mag     <= product[WIDTH-1] ? (~product + 1'b1) : product;
            sign    <= product[WIDTH-1];
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[SW-2:0], mag[WIDTH-1]};
          mag     <= {mag[WIDTH-2:0], 1'b0};
          count   <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          D0    <= scratch[19:16];
          D1    <= scratch[15:12];
          D2    <= scratch[11:8];
          D3    <= scratch[7:4];
          D4    <= scratch[3:0];
          // A zero magnitude is never reported as negative.
          neg   <= sign & (scratch != '0);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/signed_bcd_digitizer.md
Name: signed_bcd_digitizer

Overview:
- Converts the multiplier's 16-bit two's-complement product into a sign flag and five BCD digits D0..D4. D0 is the ten-thousands digit and D4 is the units digit.
- Feeds the display's 3-digit scrolling window, which consumes D0..D4.
- Sequential double-dabble converter: one shift per clock, start/busy/done handshake.
- Output digits change atomically, only at conversion end, so the window never shows partial results.

Parameters:
- WIDTH, 16, product width in bits. Fixed at 16; five digits cover magnitudes up to 32768.
- DIGITS, 5, number of BCD output digits. Fixed at 5.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. 0 = reset.
- start  input  1  level-sampled request. Accepted only when the FSM is in IDLE.
- product  input  16  signed two's-complement value. Sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- neg  output  1  sign of the last converted product (1 = negative).
- D0, D1, D2, D3, D4  output  4 each  BCD digits, D0 most significant. Each is always in the range 0..9.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy=0, done=0, neg=0, D0..D4=0. Working registers and bit counter are cleared.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On a rising edge with start=1:
    - mag = |product| as 16-bit unsigned (16'h8000 gives 32768, no overflow).
    - sign = product[15].
    - BCD scratch = 0, count = 0.
    - busy goes to 1, state goes to SHIFT.
  - start=0: remain in IDLE. Outputs hold their values.
- SHIFT, each edge:
  - For every scratch nibble >= 5, add 3.
  - Then shift {scratch, mag} left by one.
  - count increments.
  - After the 16th SHIFT edge (count reaches 15 before increment), state goes to FINISH.
- FINISH, one edge:
  - D0..D4 are loaded from the scratch nibbles, with D0 = bits [19:16] and D4 = bits [3:0].
  - neg = sign, except neg is forced to 0 when the magnitude is 0.
  - done=1 and busy=0 (both registered). State goes to IDLE.
- done is high for exactly one cycle. It drops on the next edge regardless of start.
- Latency: start sampled at edge N; shifts occur at edges N+1..N+16; outputs and done update at edge N+17.
- Back-to-back: start may be high during the done cycle. It is sampled at edge N+18 (state is IDLE by then). Throughput is one conversion per 18 cycles.
- start while busy=1: ignored. It is not queued, and product is not re-sampled.
- Outputs D0..D4 and neg are stable during SHIFT. They hold the previous result until FINISH.
- Reset mid-conversion: abort immediately. All outputs return to 0, no done pulse, next start is accepted normally.
- Scratch register is 20 bits and the add-3 is applied per nibble. An adder carry must never cross a nibble boundary.

Test Plan:
- Reset: rst=0 for 3 cycles, then release. Required: D0..D4=0, neg=0, busy=0, done=0; outputs stay 0 with start=0.
- product=16'd12345, start for 1 cycle at edge N. Required:
  - busy=1 from N through N+16.
  - At N+17: done=1 for one cycle, D0..D4=1,2,3,4,5, neg=0.
  - Outputs unchanged before N+17.
- product=16'hC000 (-16384). Required: D0..D4=1,6,3,8,4, neg=1. Then product=16'h8000 (-32768) back-to-back, start held high through the done cycle. Required: second result 3,2,7,6,8, neg=1, second done 18 cycles after the first.
- product=16'd42, start; then at edge N+5 start=1 with product=16'd99. Required: exactly one done pulse, at N+17, D0..D4=0,0,0,4,2. Separately, product=16'd0 gives all digits 0 and neg=0; product=16'hFFFF gives 0,0,0,0,1 and neg=1.
- Start a conversion of 16'd9999, assert rst=0 at edge N+8. Required: immediate busy=0 and zeroed outputs, no done. After release, a conversion of 16'd500 gives 0,0,5,0,0 with done at the correct latency.
